uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver paired with the existing uart transmitter. Format is 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity. The block oversamples the asynchronous serial line with the system clock and samples each bit at its midpoint. Each received byte is presented on data_out with a one-cycle data_out_flag strobe, so it drops straight into the same byte-plus-flag interface the transmitter consumes.

Parameters:
CLK_FEQ, 26'd50_000_000, system clock frequency in Hz
UART_BOT, 15'd9600, baud rate in bit/s
Derived localparam BIT_CNT_MAX = CLK_FEQ / UART_BOT (5208 at defaults); legal range 4..65535.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
uart_rx  input  1  asynchronous serial line, idle high
data_out  output  8  last correctly framed byte; held until the next good frame
data_out_flag  output  1  one-cycle pulse, data_out valid and newly updated
frame_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values: data_out=8'h00, data_out_flag=0, frame_err=0, busy=0, state=IDLE, baud_cnt=0, bit_idx=0, shift register 0.
- Input conditioning: uart_rx passes through a 2-FF synchronizer to give rx_s, then one more register gives rx_d. All three flops reset to 0, which keeps the receiver unarmed out of reset.
- Start detection: falling edge = rx_d & ~rx_s. A line held low through reset release never triggers; the line must go high and then low.
- baud_cnt is 16-bit and cleared on every state transition. bit_idx is 3-bit.
- IDLE: on a falling edge, go to START with baud_cnt=0. busy rises on the next cycle.
- START: count up. When baud_cnt == BIT_CNT_MAX/2 - 1, sample rx_s.
  - rx_s=0 (valid start bit): go to DATA, bit_idx=0.
  - rx_s=1 (glitch / false start): return to IDLE; no outputs change.
- DATA: count up. When baud_cnt == BIT_CNT_MAX - 1, write shift[bit_idx] = rx_s and increment bit_idx. After bit_idx 7 is sampled, go to STOP. Sampling therefore stays mid-bit.
- STOP: when baud_cnt == BIT_CNT_MAX - 1, sample rx_s and return to IDLE in the same cycle.
  - rx_s=1: on the next clock, data_out <= shift and data_out_flag=1 for exactly one cycle.
  - rx_s=0: on the next clock, frame_err=1 for one cycle; data_out is unchanged and data_out_flag stays 0.
- Returning to IDLE at mid-stop-bit leaves half a bit of margin, so back-to-back frames with no idle gap are received.
- A falling edge seen while not in IDLE is ignored.
- data_out_flag and frame_err are never high together.
- Latency: flag rises 2 (sync) + 1 (edge) + BIT_CNT_MAX/2 + 9*BIT_CNT_MAX + 1 clocks after the start-bit falling edge on the pin, within ±1 clock of synchronizer uncertainty.
- Reset mid-frame: all state is abandoned immediately and no flag is produced. Reception resumes at the next high-to-low transition after release.
- Baud error tolerance comes from the mid-bit sampling alone; there is no majority voting.

Decomposition:
- Shared constants header holds:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the BIT_CNT_MAX derivation, so the transmitter and receiver compute the bit period identically.
- One natural sub-module: sync_2ff, a 1-bit 2-stage synchronizer with parameterizable reset value (set to 0 here). It is reusable for other asynchronous inputs.
- Counter, FSM and shift register stay in uart_rx.

Test Plan:
All tests use CLK_FEQ=1_000_000 and UART_BOT=100_000, giving BIT_CNT_MAX=10.
1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 10 clk/bit -> data_out=8'hA5, data_out_flag high exactly 1 cycle, frame_err=0, busy falls by the end of the stop bit.
2. Back-to-back 0x00 then 0xFF with zero idle between frames -> two flags about 100 clk apart, with data_out 8'h00 then 8'hFF.
3. Low glitch of 3 clk on an idle line -> busy pulses about 5 clk and returns to 0; no flag, no frame_err, data_out unchanged.
4. Receive 0x5A, then a frame of 0x33 with stop bit driven low -> frame_err pulses 1 cycle, data_out stays 8'h5A, data_out_flag stays 0.
5. Assert rst for 2 clk while in DATA (bit 4) -> all outputs return to reset values, no flag. A following 0x3C frame is received correctly.
6. Hold uart_rx low across reset release for 50 clk, then high 20 clk, then send 0xC3 -> nothing is received during the low period; 0xC3 is then received with one flag.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART constants: receiver FSM encoding and bit-period derivation,
// kept here so transmitter and receiver compute the bit period identically.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Clocks per bit; legal results are 4..65535, so 16 bits always suffice.
   function automatic logic [15:0] bit_cnt_max(input int unsigned clk_feq,
                                               input int unsigned uart_bot);
      int unsigned q;
      q = clk_feq / uart_bot;
      return q[15:0];
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte plus strobes out.
// master: the receiver; slave: whatever drives the line and consumes bytes.
interface uart_rx_if;
   logic       uart_rx;
   logic [7:0] data_out;
   logic       data_out_flag;
   logic       frame_err;
   logic       busy;

   modport master (
      input  uart_rx,
      output data_out, data_out_flag, frame_err, busy
   );

   modport slave (
      output uart_rx,
      input  data_out, data_out_flag, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// 1-bit two-stage synchronizer for asynchronous inputs, reset value selectable.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops to settle metastability before use.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, byte + one-cycle flag.
import uart_rx_pkg::*;

module uart_rx #(
   // Held as int so test baud rates above the 15-bit default width still fit.
   parameter int unsigned CLK_FEQ  = 26'd50_000_000,
   parameter int unsigned UART_BOT = 15'd9600
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.master bus
);

   localparam logic [15:0] BIT_CNT_MAX = bit_cnt_max(CLK_FEQ, UART_BOT);
   localparam logic [15:0] BIT_LAST    = BIT_CNT_MAX - 16'd1;
   localparam logic [15:0] HALF_LAST   = (BIT_CNT_MAX / 16'd2) - 16'd1;

   logic       rx_s;
   logic       rx_d;
   logic       fall;

   rx_state_t  state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        stop_ok;
   logic        stop_bad;

   logic [7:0]  data_out_r;
   logic        flag_r;
   logic        ferr_r;
   logic        busy_r;

   // Synchronizer resets low so a line held low through reset cannot look like a start.
   sync_2ff #(.RST_VAL(1'b0)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.uart_rx),
      .q   (rx_s)
   );

   // One extra stage of the synchronized line for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_d <= 1'b0;
      else      rx_d <= rx_s;
   end

   assign fall = rx_d & ~rx_s;

   // Receiver FSM with bit counter, shift register and registered outputs.
   // The stop-bit verdict is latched first and published one clock later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         baud_cnt   <= 16'd0;
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         stop_ok    <= 1'b0;
         stop_bad   <= 1'b0;
         data_out_r <= 8'h00;
         flag_r     <= 1'b0;
         ferr_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         stop_ok  <= 1'b0;
         stop_bad <= 1'b0;
         flag_r   <= stop_ok;
         ferr_r   <= stop_bad;
         if (stop_ok) data_out_r <= shift;

         case (state)
            IDLE: begin
               baud_cnt <= 16'd0;
               if (fall) begin
                  state  <= START;
                  busy_r <= 1'b1;
               end
            end
            START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= 16'd0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     // Line back high at mid-start: treat as a glitch.
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt       <= 16'd0;
                  shift[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_cnt == BIT_LAST) begin
                  // Leave at mid-stop so a back-to-back start edge is caught.
                  baud_cnt <= 16'd0;
                  state    <= IDLE;
                  busy_r   <= 1'b0;
                  stop_ok  <= rx_s;
                  stop_bad <= ~rx_s;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= 16'd0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out      = data_out_r;
   assign bus.data_out_flag = flag_r;
   assign bus.frame_err     = ferr_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

   localparam int BIT = 10;

   logic clk;
   logic rst;
   uart_rx_if bus ();

   uart_rx #(.CLK_FEQ(1_000_000), .UART_BOT(100_000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Output event recorder, sampled on the falling edge.
   int flag_cyc = 0, flag_rise = 0, ferr_cyc = 0, ferr_rise = 0, both_cyc = 0, busy_cyc = 0;
   time flag_t[$];
   logic [7:0] flag_d[$];
   logic flag_q = 1'b0, ferr_q = 1'b0;

   always @(negedge clk) begin
      if (bus.data_out_flag) begin
         flag_cyc++;
         if (!flag_q) begin
            flag_rise++;
            flag_t.push_back($time);
            flag_d.push_back(bus.data_out);
         end
      end
      if (bus.frame_err) begin
         ferr_cyc++;
         if (!ferr_q) ferr_rise++;
      end
      if (bus.data_out_flag && bus.frame_err) both_cyc++;
      if (bus.busy) busy_cyc++;
      flag_q = bus.data_out_flag;
      ferr_q = bus.frame_err;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one frame; returns the time the start bit fell on the pin.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, output time t0);
      bus.uart_rx = 1'b0;
      t0 = $time;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         bus.uart_rx = b[i];
         idle(BIT);
      end
      bus.uart_rx = stop_v;
      idle(BIT);
      bus.uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.uart_rx = 1'b1;
      idle(3);
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.data_out); end
      checks++; if (bus.data_out_flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %b want 0", bus.data_out_flag); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", bus.frame_err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      rst = 1'b1;
      idle(10);
   endtask

   task automatic test_single;
      int f0, fc0, e0, lat;
      time t0;
      f0 = flag_rise; fc0 = flag_cyc; e0 = ferr_rise;
      send_frame(8'hA5, 1'b1, t0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end: got %b want 0", bus.busy); end
      idle(5);
      checks++; if (flag_rise - f0 != 1) begin errors++; $display("FAIL a5_flag_count: got %0d want 1", flag_rise - f0); end
      checks++; if (flag_cyc - fc0 != 1) begin errors++; $display("FAIL a5_flag_width: got %0d want 1", flag_cyc - fc0); end
      checks++; if (ferr_rise != e0) begin errors++; $display("FAIL a5_ferr: got %0d want 0", ferr_rise - e0); end
      checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", bus.data_out); end
      lat = (flag_t.size() > f0) ? int'((flag_t[f0] - t0) / 10) : -1;
      checks++; if (lat < 98 || lat > 100) begin errors++; $display("FAIL a5_latency: got %0d want 99+-1", lat); end
      checks++; if (flag_d.size() <= f0 || flag_d[f0] !== 8'hA5) begin errors++; $display("FAIL a5_data_at_flag: got %h want a5", (flag_d.size() > f0) ? flag_d[f0] : 8'hxx); end
   endtask

   task automatic test_back_to_back;
      int f0, gap;
      time t0, t1;
      f0 = flag_rise;
      send_frame(8'h00, 1'b1, t0);
      send_frame(8'hFF, 1'b1, t1);
      idle(5);
      checks++; if (flag_rise - f0 != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", flag_rise - f0); end
      checks++; if (flag_d.size() <= f0 || flag_d[f0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", (flag_d.size() > f0) ? flag_d[f0] : 8'hxx); end
      checks++; if (flag_d.size() <= f0 + 1 || flag_d[f0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", (flag_d.size() > f0 + 1) ? flag_d[f0+1] : 8'hxx); end
      gap = (flag_t.size() > f0 + 1) ? int'((flag_t[f0+1] - flag_t[f0]) / 10) : -1;
      checks++; if (gap < 99 || gap > 101) begin errors++; $display("FAIL b2b_gap: got %0d want 100", gap); end
      checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h want ff", bus.data_out); end
   endtask

   task automatic test_glitch;
      int f0, e0, b0;
      f0 = flag_rise; e0 = ferr_rise; b0 = busy_cyc;
      bus.uart_rx = 1'b0;
      idle(3);
      bus.uart_rx = 1'b1;
      idle(20);
      checks++; if (busy_cyc - b0 < 4 || busy_cyc - b0 > 6) begin errors++; $display("FAIL glitch_busy: got %0d cycles want 5", busy_cyc - b0); end
      checks++; if (flag_rise != f0) begin errors++; $display("FAIL glitch_flag: got %0d want 0", flag_rise - f0); end
      checks++; if (ferr_rise != e0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_rise - e0); end
      checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL glitch_data: got %h want ff", bus.data_out); end
   endtask

   task automatic test_frame_err;
      int f0, e0, ec0;
      time t0;
      send_frame(8'h5A, 1'b1, t0);
      idle(5);
      checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL ferr_pre_data: got %h want 5a", bus.data_out); end
      f0 = flag_rise; e0 = ferr_rise; ec0 = ferr_cyc;
      send_frame(8'h33, 1'b0, t0);
      idle(10);
      checks++; if (ferr_rise - e0 != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_rise - e0); end
      checks++; if (ferr_cyc - ec0 != 1) begin errors++; $display("FAIL ferr_width: got %0d want 1", ferr_cyc - ec0); end
      checks++; if (flag_rise != f0) begin errors++; $display("FAIL ferr_flag: got %0d want 0", flag_rise - f0); end
      checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL ferr_data: got %h want 5a", bus.data_out); end
   endtask

   task automatic test_reset_mid_frame;
      int f0;
      time t0;
      logic [7:0] b;
      b = 8'h3C;
      f0 = flag_rise;
      bus.uart_rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 4; i++) begin
         bus.uart_rx = b[i];
         idle(BIT);
      end
      bus.uart_rx = b[4];
      idle(5);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
      rst = 1'b0;
      idle(1);
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", bus.data_out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      checks++; if (bus.data_out_flag !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got %b%b want 00", bus.data_out_flag, bus.frame_err); end
      idle(1);
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      idle(30);
      checks++; if (flag_rise != f0) begin errors++; $display("FAIL midrst_noflag: got %0d want 0", flag_rise - f0); end
      send_frame(8'h3C, 1'b1, t0);
      idle(5);
      checks++; if (flag_rise - f0 != 1) begin errors++; $display("FAIL midrst_after_count: got %0d want 1", flag_rise - f0); end
      checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL midrst_after_data: got %h want 3c", bus.data_out); end
   endtask

   task automatic test_low_through_reset;
      int f0, b0;
      time t0;
      rst = 1'b0;
      bus.uart_rx = 1'b0;
      idle(3);
      f0 = flag_rise; b0 = busy_cyc;
      rst = 1'b1;
      idle(50);
      checks++; if (busy_cyc != b0) begin errors++; $display("FAIL lowrst_busy: got %0d cycles want 0", busy_cyc - b0); end
      checks++; if (flag_rise != f0) begin errors++; $display("FAIL lowrst_flag: got %0d want 0", flag_rise - f0); end
      bus.uart_rx = 1'b1;
      idle(20);
      send_frame(8'hC3, 1'b1, t0);
      idle(5);
      checks++; if (flag_rise - f0 != 1) begin errors++; $display("FAIL lowrst_after_count: got %0d want 1", flag_rise - f0); end
      checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL lowrst_after_data: got %h want c3", bus.data_out); end
   endtask

   initial begin
      rst = 1'b0;
      bus.uart_rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
      test_low_through_reset();
      checks++; if (both_cyc != 0) begin errors++; $display("FAIL flag_and_ferr_together: got %0d cycles want 0", both_cyc); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
